// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a programmed number of 16-bit unsigned products arriving one beat at a
// time over a valid/ready handshake, then presents the total with a sticky
// overflow flag until the downstream side consumes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new run (only honoured in IDLE)
//   len        number of products to sum, sampled with start; 0 means 256
//   prod       unsigned product from the upstream multiplier
//   in_valid   prod is valid this cycle
//   in_ready   block accepts prod this cycle (high in ACCUM)
//   sum        accumulator register, meaningful while out_valid is high
//   ovf        sticky: a carry left the top accumulator bit during this run
//   out_valid  result available (high in DONE)
//   out_ready  downstream consumes the result
//   busy       high whenever the block is not IDLE
// ---------------------------------------------------------------------------
module product_accumulator #(
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       len,
   input  logic [15:0]      prod,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] sum,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [8:0]       count_q, count_d;
   logic [8:0]       target_q, target_d;
   logic             ovf_q, ovf_d;

   // One extra bit on the adder captures the carry that feeds the sticky flag.
   logic [ACC_W:0]   sum_ext;
   logic [8:0]       count_inc;

   assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};
   assign count_inc = count_q + 9'd1;

   // Handshake outputs are pure decodes of the state register so they never
   // depend combinationally on in_valid or out_ready.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = acc_q;
   assign ovf       = ovf_q;

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      count_d  = count_q;
      target_d = target_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // A zero length encodes a full 256-beat run.
               target_d = (len == 8'd0) ? 9'd256 : {1'b0, len};
               acc_d    = '0;
               count_d  = '0;
               ovf_d    = 1'b0;
               state_d  = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d   = sum_ext[ACC_W-1:0];
               count_d = count_inc;
               if (sum_ext[ACC_W]) begin
                  ovf_d = 1'b1;
               end
               if (count_inc == target_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         count_q  <= '0;
         target_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         target_q <= target_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Self-checking bench for product_accumulator. Two instances share every
// input: one at the default 24-bit width and one at 16 bits so wrap and the
// sticky overflow flag can be observed on the same stimulus.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic [15:0] prod;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready, out_valid, busy, ovf;
   logic [23:0] sum;
   logic        in_ready16, out_valid16, busy16, ovf16;
   logic [15:0] sum16;

   int checks;
   int errors;

   logic [15:0] beat_data [256];

   typedef struct {
      logic [7:0]  len;
      int          nbeats;
      bit          bubbles;
      logic [15:0] p0, p1, p2, p3;
      logic [23:0] exp_sum;
      logic        exp_ovf;
      logic [15:0] exp_sum16;
      logic        exp_ovf16;
   } vec_t;

   vec_t vecs [5];

   product_accumulator #(.ACC_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
      .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .ovf(ovf),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   product_accumulator #(.ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
      .in_valid(in_valid), .in_ready(in_ready16), .sum(sum16), .ovf(ovf16),
      .out_valid(out_valid16), .out_ready(out_ready), .busy(busy16)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the bench's expected value.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Start a run of nbeats beats taken from beat_data, optionally with a
   // bubble before every beat after the first. Returns on the negedge one
   // cycle after the final accepted beat, where out_valid must be high.
   task automatic applyStimulus(input logic [7:0] l, input int nbeats,
                                input bit bubbles);
      @(negedge clk);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("in_ready_accum", in_ready, 1);
      for (int i = 0; i < nbeats; i++) begin
         if (bubbles && i > 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         checkOutput("no_early_out_valid", out_valid, 0);
         in_valid = 1'b1;
         prod     = beat_data[i];
         @(negedge clk);
         in_valid = 1'b0;
      end
      checkOutput("out_valid_latency", out_valid, 1);
      checkOutput("in_ready_done", in_ready, 0);
   endtask

   // Consume the result and confirm the block returns to IDLE.
   task automatic drainResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("idle_after_handshake", busy, 0);
      checkOutput("out_valid_cleared", out_valid, 0);
   endtask

   initial begin
      int model;
      logic [7:0] a, b;

      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      len       = 8'd0;
      prod      = 16'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Directed vector table: len, beats, bubbles, four products, then
      // expected 24-bit sum/ovf and 16-bit sum/ovf.
      vecs[0] = '{8'd3, 3, 1'b0, 16'd100, 16'd200, 16'd300, 16'd0,
                  24'd600, 1'b0, 16'd600, 1'b0};
      vecs[1] = '{8'd4, 4, 1'b1, 16'd10, 16'd10, 16'd10, 16'd10,
                  24'd40, 1'b0, 16'd40, 1'b0};
      vecs[2] = '{8'd2, 2, 1'b0, 16'd65025, 16'd65025, 16'd0, 16'd0,
                  24'd130050, 1'b0, 16'd64514, 1'b1};
      vecs[3] = '{8'd1, 1, 1'b0, 16'd7, 16'd0, 16'd0, 16'd0,
                  24'd7, 1'b0, 16'd7, 1'b0};
      vecs[4] = '{8'd4, 4, 1'b0, 16'd65535, 16'd65535, 16'd65535, 16'd65535,
                  24'd262140, 1'b0, 16'd65532, 1'b1};

      // Reset state.
      #12;
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_ovf", ovf, 0);
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven runs.
      for (int v = 0; v < 5; v++) begin
         beat_data[0] = vecs[v].p0;
         beat_data[1] = vecs[v].p1;
         beat_data[2] = vecs[v].p2;
         beat_data[3] = vecs[v].p3;
         applyStimulus(vecs[v].len, vecs[v].nbeats, vecs[v].bubbles);
         checkOutput("vec_sum", sum, vecs[v].exp_sum);
         checkOutput("vec_ovf", ovf, vecs[v].exp_ovf);
         checkOutput("vec_sum16", sum16, vecs[v].exp_sum16);
         checkOutput("vec_ovf16", ovf16, vecs[v].exp_ovf16);
         drainResult();
      end

      // Full-length run: len=0 means 256 beats.
      for (int i = 0; i < 256; i++) beat_data[i] = 16'd65025;
      applyStimulus(8'd0, 256, 1'b0);
      checkOutput("full_sum", sum, 16646400);
      checkOutput("full_ovf", ovf, 0);
      checkOutput("full_ovf16", ovf16, 1);
      drainResult();

      // Backpressure: hold the result with out_ready low, and pulse start
      // while in DONE; neither may disturb the held result.
      for (int i = 0; i < 4; i++) beat_data[i] = 16'd10;
      applyStimulus(8'd4, 4, 1'b1);
      for (int c = 0; c < 5; c++) begin
         start    = (c == 2);
         len      = 8'd1;
         in_valid = 1'b1;
         prod     = 16'd99;
         @(negedge clk);
         checkOutput("hold_sum", sum, 40);
         checkOutput("hold_out_valid", out_valid, 1);
         checkOutput("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      // Start during the handshake cycle is also ignored.
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      checkOutput("start_ignored_busy", busy, 0);
      @(negedge clk);
      checkOutput("still_idle", busy, 0);
      checkOutput("held_sum_after_idle", sum, 40);

      // Reset mid-run aborts immediately.
      for (int i = 0; i < 10; i++) beat_data[i] = 16'd50;
      @(negedge clk);
      start = 1'b1;
      len   = 8'd10;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         prod     = beat_data[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("pre_abort_sum", sum, 200);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_sum", sum, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("no_out_valid_after_abort", out_valid, 0);
      beat_data[0] = 16'd7;
      applyStimulus(8'd1, 1, 1'b0);
      checkOutput("post_abort_sum", sum, 7);
      drainResult();

      // Random multiplier chain: 1000 operand pairs in runs of 8.
      for (int r = 0; r < 125; r++) begin
         model = 0;
         for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            beat_data[i] = 16'(a) * 16'(b);
            model += int'(a) * int'(b);
         end
         applyStimulus(8'd8, 8, 1'b0);
         checkOutput("chain_sum", sum, model);
         drainResult();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
